pi_spi_bridge: RTL and testbench



---
 rtl/pi_spi_bridge.sv | 274 +++++++++++++++++++++++++++
 tb/tb_pi_spi_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_spi_bridge.sv
// pi_spi_bridge: SPI slave (mode 0, oversampled) to request/ack bus bridge.
// Command + LSB-first address framing, burst writes/reads, status read.
`timescale 1ns/1ps
module pi_spi_bridge #(
  parameter int         ADDR_BYTES = 4,
  parameter logic [7:0] CMD_WR     = 8'hA0,
  parameter logic [7:0] CMD_RD     = 8'hA1,
  parameter logic [7:0] CMD_WR_FIX = 8'hA2,
  parameter logic [7:0] CMD_RD_FIX = 8'hA3,
  parameter logic [7:0] CMD_STAT   = 8'hA4,
  localparam int        AW         = 8 * ADDR_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_clk,
  input  logic          ss,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_dato,
  input  logic [7:0]    bus_dati,
  output logic          bus_req,
  output logic          bus_we,
  input  logic          bus_ack,
  output logic          frame_act
);

  typedef enum logic [1:0] {
    PH_CMD,
    PH_ADDR,
    PH_DATA,
    PH_IGN
  } phase_e;

  logic [1:0] sck_sync_q;
  logic [1:0] ss_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sck_prev_q;

  // Two-flop synchronisers plus previous-SCK flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= 2'b00;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], spi_clk};
      ss_sync_q   <= {ss_sync_q[0], ss};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall;

  assign sck_s    = sck_sync_q[1];
  assign ss_s     = ss_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  phase_e        phase_q, phase_d;
  logic [2:0]    bit_ctr_q, bit_ctr_d;
  logic [1:0]    byte_ctr_q, byte_ctr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    sin_q, sin_d;
  logic [7:0]    sout_q, sout_d;
  logic [AW-1:0] addr_sh_q, addr_sh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dato_q, dato_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic          inc_q, inc_d;
  logic          ovf_q, ovf_d;
  logic [6:0]    unk_q, unk_d;
  logic [7:0]    rd_buf_q, rd_buf_d;
  logic          buf_vld_q, buf_vld_d;
  logic          load_pend_q, load_pend_d;
  logic          alp_q, alp_d;
  logic          frame_act_q, frame_act_d;

  logic [7:0] byte_in;
  logic       byte_done;
  logic       is_wr, is_rd;
  logic       cmd_known;

  assign byte_in   = {sin_q[6:0], mosi_s};
  assign byte_done = sck_rise && (bit_ctr_q == 3'd7);
  assign is_wr     = (cmd_q == CMD_WR) || (cmd_q == CMD_WR_FIX);
  assign is_rd     = (cmd_q == CMD_RD) || (cmd_q == CMD_RD_FIX);
  assign cmd_known = (byte_in == CMD_WR) || (byte_in == CMD_RD) ||
                     (byte_in == CMD_WR_FIX) || (byte_in == CMD_RD_FIX);

  // Next-state: bus ack first, then SPI framing, then deferred address load
  always_comb begin
    phase_d     = phase_q;
    bit_ctr_d   = bit_ctr_q;
    byte_ctr_d  = byte_ctr_q;
    cmd_d       = cmd_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    addr_sh_d   = addr_sh_q;
    addr_d      = addr_q;
    dato_d      = dato_q;
    req_d       = req_q;
    we_d        = we_q;
    inc_d       = inc_q;
    ovf_d       = ovf_q;
    unk_d       = unk_q;
    rd_buf_d    = rd_buf_q;
    buf_vld_d   = buf_vld_q;
    load_pend_d = load_pend_q;
    alp_d       = alp_q;
    frame_act_d = ~ss_s;

    if (req_q && bus_ack) begin
      req_d = 1'b0;
      if (inc_q) addr_d = addr_q + AW'(1);
      if (!we_q) begin
        rd_buf_d  = bus_dati;
        buf_vld_d = 1'b1;
      end
    end

    if (ss_s) begin
      phase_d     = PH_CMD;
      bit_ctr_d   = 3'd0;
      byte_ctr_d  = 2'd0;
      cmd_d       = 8'h00;
      sin_d       = 8'h00;
      sout_d      = 8'hFF;
      load_pend_d = 1'b0;
      alp_d       = 1'b0;
      buf_vld_d   = 1'b0;
    end else if (sck_rise) begin
      sin_d     = byte_in;
      bit_ctr_d = bit_ctr_q + 3'd1;
      if (byte_done) begin
        unique case (phase_q)
          PH_CMD: begin
            cmd_d = byte_in;
            if (cmd_known) begin
              phase_d = PH_ADDR;
            end else if (byte_in == CMD_STAT) begin
              phase_d     = PH_IGN;
              load_pend_d = 1'b1;
            end else begin
              phase_d = PH_IGN;
              if (unk_q != 7'h7F) unk_d = unk_q + 7'd1;
            end
          end
          PH_ADDR: begin
            for (int i = 0; i < ADDR_BYTES; i++) begin
              if (byte_ctr_q == 2'(i)) addr_sh_d[8*i +: 8] = byte_in;
            end
            if (byte_ctr_q == 2'(ADDR_BYTES - 1)) begin
              phase_d = PH_DATA;
              alp_d   = 1'b1;
            end else begin
              byte_ctr_d = byte_ctr_q + 2'd1;
            end
          end
          PH_DATA: begin
            if (is_wr) begin
              if (req_d || alp_q) begin
                ovf_d = 1'b1;
              end else begin
                dato_d = byte_in;
                req_d  = 1'b1;
                we_d   = 1'b1;
                inc_d  = (cmd_q == CMD_WR);
              end
            end else if (is_rd) begin
              load_pend_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (sck_fall) begin
      if (load_pend_q) begin
        load_pend_d = 1'b0;
        if (cmd_q == CMD_STAT) begin
          sout_d = {ovf_q, unk_q};
          ovf_d  = 1'b0;
          unk_d  = 7'd0;
        end else begin
          if (buf_vld_d) begin
            sout_d    = rd_buf_d;
            buf_vld_d = 1'b0;
          end else begin
            sout_d = 8'hFF;
            ovf_d  = 1'b1;
          end
          if (!req_d && !alp_q) begin
            req_d = 1'b1;
            we_d  = 1'b0;
            inc_d = (cmd_q == CMD_RD);
          end
        end
      end else begin
        sout_d = {sout_q[6:0], 1'b1};
      end
    end

    // First request of a frame waits until the bus is free
    if (alp_d && !req_d) begin
      addr_d = addr_sh_d;
      alp_d  = 1'b0;
      if (is_rd) begin
        req_d = 1'b1;
        we_d  = 1'b0;
        inc_d = (cmd_q == CMD_RD);
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_CMD;
      bit_ctr_q   <= 3'd0;
      byte_ctr_q  <= 2'd0;
      cmd_q       <= 8'h00;
      sin_q       <= 8'h00;
      sout_q      <= 8'hFF;
      addr_sh_q   <= '0;
      addr_q      <= '0;
      dato_q      <= 8'h00;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      inc_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unk_q       <= 7'd0;
      rd_buf_q    <= 8'h00;
      buf_vld_q   <= 1'b0;
      load_pend_q <= 1'b0;
      alp_q       <= 1'b0;
      frame_act_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      bit_ctr_q   <= bit_ctr_d;
      byte_ctr_q  <= byte_ctr_d;
      cmd_q       <= cmd_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      addr_sh_q   <= addr_sh_d;
      addr_q      <= addr_d;
      dato_q      <= dato_d;
      req_q       <= req_d;
      we_q        <= we_d;
      inc_q       <= inc_d;
      ovf_q       <= ovf_d;
      unk_q       <= unk_d;
      rd_buf_q    <= rd_buf_d;
      buf_vld_q   <= buf_vld_d;
      load_pend_q <= load_pend_d;
      alp_q       <= alp_d;
      frame_act_q <= frame_act_d;
    end
  end

  assign miso      = sout_q[7];
  assign miso_oe   = frame_act_q;
  assign frame_act = frame_act_q;
  assign bus_addr  = addr_q;
  assign bus_dato  = dato_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;

endmodule

// File: tb/tb_pi_spi_bridge.sv
// tb_pi_spi_bridge: directed SPI frames against a bus responder,
// bus transactions and miso bytes checked through scoreboard queues.
`timescale 1ns/1ps
module tb_pi_spi_bridge;

  localparam int  AW   = 32;
  localparam time HALF = 60ns;

  logic          clk;
  logic          rst;
  logic          spi_clk;
  logic          ss;
  logic          mosi;
  logic          miso;
  logic          miso_oe;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_dato;
  logic [7:0]    bus_dati;
  logic          bus_req;
  logic          bus_we;
  logic          bus_ack;
  logic          frame_act;

  pi_spi_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .bus_addr  (bus_addr),
    .bus_dato  (bus_dato),
    .bus_dati  (bus_dati),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_ack   (bus_ack),
    .frame_act (frame_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [40:0] exp_bus[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  rd_data[$];
  bit          ack_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus responder: ack 2 clk after req, compare each transaction
  initial begin
    int          cnt;
    logic [40:0] obs;
    logic [40:0] exp;
    cnt      = 0;
    bus_ack  = 1'b0;
    bus_dati = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt     = 0;
        bus_ack = 1'b0;
      end else if (bus_ack) begin
        bus_ack = 1'b0;
        cnt     = 0;
      end else if (bus_req && !ack_hold) begin
        cnt++;
        if (cnt >= 2) begin
          bus_ack  = 1'b1;
          bus_dati = (rd_data.size() != 0) ? rd_data.pop_front() : 8'hEE;
          obs = {bus_we, bus_addr, bus_we ? bus_dato : 8'h00};
          exp = (exp_bus.size() != 0) ? exp_bus.pop_front() : 'x;
          check("bus_txn", 64'(obs), 64'(exp));
        end
      end
    end
  end

  task automatic xfer(input logic [7:0] tx);
    logic [7:0] rx;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #(HALF);
      rx[i] = miso;
      spi_clk = 1'b1;
      #(HALF);
      spi_clk = 1'b0;
    end
    e = (exp_miso.size() != 0) ? exp_miso.pop_front() : 'x;
    check("miso_byte", 64'(rx), 64'(e));
  endtask

  task automatic send(input logic [7:0] tx, input logic [7:0] exp);
    exp_miso.push_back(exp);
    xfer(tx);
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    #(HALF);
  endtask

  task automatic frame_end();
    #(HALF);
    ss = 1'b1;
    #(HALF * 2);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus_req && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, 64'(k < 400), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 64'(miso), 64'd1);
    check({tag, "_miso_oe"}, 64'(miso_oe), 64'd0);
    check({tag, "_req"}, 64'(bus_req), 64'd0);
    check({tag, "_we"}, 64'(bus_we), 64'd0);
    check({tag, "_addr"}, 64'(bus_addr), 64'd0);
    check({tag, "_dato"}, 64'(bus_dato), 64'd0);
    check({tag, "_frame_act"}, 64'(frame_act), 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    ss      = 1'b1;
    spi_clk = 1'b0;
    mosi    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Incrementing write burst
    exp_bus.push_back({1'b1, 32'h12345678, 8'hAA});
    exp_bus.push_back({1'b1, 32'h12345679, 8'hBB});
    frame_begin();
    send(8'hA0, 8'hFF);
    send(8'h78, 8'hFF);
    send(8'h56, 8'hFF);
    send(8'h34, 8'hFF);
    send(8'h12, 8'hFF);
    send(8'hAA, 8'hFF);
    send(8'hBB, 8'hFF);
    frame_end();
    wait_idle("wr_idle");
    check("wr_end_addr", 64'(bus_addr), 64'h1234567A);

    // Incrementing read burst with prefetch
    rd_data.push_back(8'h11);
    rd_data.push_back(8'h22);
    rd_data.push_back(8'h33);
    exp_bus.push_back({1'b0, 32'h00001000, 8'h00});
    exp_bus.push_back({1'b0, 32'h00001001, 8'h00});
    exp_bus.push_back({1'b0, 32'h00001002, 8'h00});
    exp_bus.push_back({1'b0, 32'h00001003, 8'h00});
    frame_begin();
    send(8'hA1, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h10, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'h11);
    send(8'h00, 8'h22);
    frame_end();
    wait_idle("rd_idle");

    // Fixed-address read burst
    rd_data.push_back(8'h5A);
    rd_data.push_back(8'h6B);
    rd_data.push_back(8'h7C);
    repeat (4) exp_bus.push_back({1'b0, 32'h00000040, 8'h00});
    frame_begin();
    send(8'hA3, 8'hFF);
    send(8'h40, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'h5A);
    send(8'h00, 8'h6B);
    frame_end();
    wait_idle("rdfix_idle");
    check("rdfix_addr", 64'(bus_addr), 64'h40);

    // Withheld ack: second write byte dropped, ovf set
    ack_hold = 1'b1;
    exp_bus.push_back({1'b1, 32'h00000100, 8'hC1});
    frame_begin();
    send(8'hA0, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h01, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'hC1, 8'hFF);
    send(8'hC2, 8'hFF);
    frame_end();
    #(HALF * 2 * 12);
    check("ovf_req_held", 64'(bus_req), 64'd1);
    ack_hold = 1'b0;
    wait_idle("ovf_idle");

    frame_begin();
    send(8'hA4, 8'hFF);
    send(8'h00, 8'h80);
    send(8'h00, 8'hFF);
    frame_end();
    frame_begin();
    send(8'hA4, 8'hFF);
    send(8'h00, 8'h00);
    frame_end();

    // Unknown commands counted, miso idle high
    repeat (3) begin
      frame_begin();
      send(8'h55, 8'hFF);
      send(8'h12, 8'hFF);
      send(8'h34, 8'hFF);
      frame_end();
    end
    frame_begin();
    send(8'hA4, 8'hFF);
    send(8'h00, 8'h03);
    frame_end();

    // Address wrap at all-ones
    exp_bus.push_back({1'b1, 32'hFFFFFFFF, 8'h11});
    exp_bus.push_back({1'b1, 32'h00000000, 8'h22});
    frame_begin();
    send(8'hA0, 8'hFF);
    send(8'hFF, 8'hFF);
    send(8'hFF, 8'hFF);
    send(8'hFF, 8'hFF);
    send(8'hFF, 8'hFF);
    send(8'h11, 8'hFF);
    send(8'h22, 8'hFF);
    frame_end();
    wait_idle("wrap_idle");
    check("wrap_end_addr", 64'(bus_addr), 64'h1);

    // Reset in the middle of a frame with a request outstanding
    ack_hold = 1'b1;
    frame_begin();
    send(8'hA0, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h02, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h00, 8'hFF);
    send(8'h77, 8'hFF);
    #(HALF);
    check("pre_rst_req", 64'(bus_req), 64'd1);
    check("pre_rst_dato", 64'(bus_dato), 64'h77);
    check("pre_rst_addr", 64'(bus_addr), 64'h200);
    check("pre_rst_frame", 64'(frame_act), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    ss = 1'b1;
    repeat (5) @(negedge clk);
    rst      = 1'b0;
    ack_hold = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_req", 64'(bus_req), 64'd0);
    check("post_rst_frame", 64'(frame_act), 64'd0);

    check("bus_q_empty", 64'(exp_bus.size()), 64'd0);
    check("miso_q_empty", 64'(exp_miso.size()), 64'd0);
    check("rd_q_empty", 64'(rd_data.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
